// File: rtl/dpi_call_responder.sv
// Responder for foreign-initiated calls: queues tagged requests in a FIFO and
// executes them strictly in order, returning exactly one tagged response each.
module dpi_call_responder #(
   parameter int unsigned ARGW       = 4,
   parameter int unsigned TAGW       = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CTX_CYCLES = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [2:0]                       req_func,
   input  logic [TAGW-1:0]                  req_tag,
   input  logic [ARGW-1:0]                  req_a,
   input  logic [ARGW-1:0]                  req_b,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [TAGW-1:0]                  rsp_tag,
   output logic [31:0]                      rsp_data,
   output logic                             rsp_err,
   output logic [$clog2(DEPTH+1):0]         outstanding
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = $clog2(DEPTH+1) + 1;
   localparam int unsigned CW = $clog2(CTX_CYCLES + 1);

   typedef struct packed {
      logic [2:0]      func;
      logic [TAGW-1:0] tag;
      logic [ARGW-1:0] a;
      logic [ARGW-1:0] b;
   } req_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   req_t            mem [DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            full, empty, push, pop;
   req_t            head;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [TAGW-1:0] ctx_tag, ctx_tag_nx;
   logic            load, rsp_done;
   logic [TAGW-1:0] ld_tag;
   logic [31:0]     ld_data;
   logic            ld_err;
   logic [ARGW:0]   sum;

   // Extra pointer bit separates full from empty when the indices match
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty     = (wr_ptr == rd_ptr);
   assign req_ready = !full;
   assign push      = req_valid && req_ready;
   assign head      = mem[rd_ptr[AW-1:0]];
   assign sum       = {1'b0, head.a} + {1'b0, head.b};

   // FIFO storage write
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= '{func: req_func, tag: req_tag, a: req_a, b: req_b};
   end

   // FIFO pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // FSM state register, context countdown and tag held across the context task
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         ctx_tag <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         ctx_tag <= ctx_tag_nx;
      end
   end

   // FSM next state: pop and execute in IDLE, count down in WAIT, hold in RESP
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      ctx_tag_nx = ctx_tag;
      pop        = 1'b0;
      load       = 1'b0;
      rsp_done   = 1'b0;
      ld_tag     = '0;
      ld_data    = '0;
      ld_err     = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (head.func == 3'd3) begin
                  cnt_nx     = CW'(CTX_CYCLES - 1);
                  ctx_tag_nx = head.tag;
                  state_nx   = S_WAIT;
               end else begin
                  load   = 1'b1;
                  ld_tag = head.tag;
                  ld_err = head.func[2];
                  case (head.func)
                     3'd0:    ld_data = 32'(|head.a);
                     3'd1:    ld_data = 32'(&head.a);
                     3'd2:    ld_data = 32'(sum);
                     default: ld_data = '0;
                  endcase
                  state_nx = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               load     = 1'b1;
               ld_tag   = ctx_tag;
               state_nx = S_RESP;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_done = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Response registers: loaded on completion, held until the handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_tag   <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (load) begin
         rsp_valid <= 1'b1;
         rsp_tag   <= ld_tag;
         rsp_data  <= ld_data;
         rsp_err   <= ld_err;
      end else if (rsp_done) begin
         rsp_valid <= 1'b0;
      end
   end

   // Calls in flight: queued plus executing or awaiting response handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         case ({push, rsp_done})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_dpi_call_responder.sv
// Scoreboard bench for dpi_call_responder: expected responses are queued on
// acceptance and compared whenever a response is presented.
module tb_dpi_call_responder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CTX   = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [2:0]  req_func;
   logic [3:0]  req_tag, req_a, req_b;
   logic        rsp_valid, rsp_ready;
   logic [3:0]  rsp_tag;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [3:0]  outstanding;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   hs_cyc[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   out_m = 0;

   dpi_call_responder #(.ARGW(4), .TAGW(4), .DEPTH(DEPTH), .CTX_CYCLES(CTX)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
      .req_tag(req_tag), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [2:0] f, input logic [3:0] t,
                                  input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      int   s;
      e.tag = t; e.data = 32'd0; e.err = 1'b0;
      s = int'(a) + int'(b);
      case (f)
         3'd0:    e.data = (a != 4'd0) ? 32'd1 : 32'd0;
         3'd1:    e.data = (a == 4'hF) ? 32'd1 : 32'd0;
         3'd2:    e.data = 32'(s);
         3'd3:    e.data = 32'd0;
         default: e.err  = 1'b1;
      endcase
      return e;
   endfunction

   // One clock: score the presented response, model handshakes, advance.
   task automatic tick();
      bit acc, hs;
      acc = req_valid && req_ready && !reset;
      hs  = rsp_valid && rsp_ready && !reset;
      if (!reset && rsp_valid) begin
         if (sb.size() == 0) begin
            check_eq("spurious_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            check_eq("rsp_tag",  32'(rsp_tag), 32'(sb[0].tag));
            check_eq("rsp_data", rsp_data,     sb[0].data);
            check_eq("rsp_err",  32'(rsp_err), 32'(sb[0].err));
         end
      end
      if (hs && sb.size() > 0) begin
         void'(sb.pop_front());
         hs_cyc.push_back(cyc);
      end
      if (acc) sb.push_back(model(req_func, req_tag, req_a, req_b));
      out_m = out_m + int'(acc) - int'(hs);
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         sb.delete();
         out_m = 0;
      end else begin
         check_eq("outstanding", 32'(outstanding), 32'(out_m));
      end
   endtask

   task automatic send(input logic [2:0] f, input logic [3:0] t,
                       input logic [3:0] a, input logic [3:0] b);
      int n;
      req_func = f; req_tag = t; req_a = a; req_b = b; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check_eq("send_timeout", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (sb.size() > 0 && n < limit) begin
         tick();
         n++;
      end
      check_eq("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_func = '0; req_tag = '0; req_a = '0; req_b = '0;
      tick(); tick();
      reset = 1'b0;
      check_eq("rst_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_tag",   32'(rsp_tag),   32'd0);
      check_eq("rst_data",  rsp_data,       32'd0);
      check_eq("rst_err",   32'(rsp_err),   32'd0);
      check_eq("rst_out",   32'(outstanding), 32'd0);
      check_eq("rst_ready", 32'(req_ready), 32'd1);

      // func0 latency and handshake
      send(3'd0, 4'd5, 4'b0100, 4'd0);
      check_eq("f0_lat_early", 32'(rsp_valid), 32'd0);
      tick();
      check_eq("f0_lat", 32'(rsp_valid), 32'd1);
      tick();
      rsp_ready = 1'b1;
      tick();
      check_eq("f0_done_valid", 32'(rsp_valid), 32'd0);
      check_eq("f0_done_out", 32'(outstanding), 32'd0);

      // back-to-back and_reduce, responses two cycles apart
      hs_cyc.delete();
      send(3'd1, 4'd1, 4'b1111, 4'd0);
      send(3'd1, 4'd2, 4'b1110, 4'd0);
      drain(20);
      check_eq("b2b_count", 32'(hs_cyc.size()), 32'd2);
      if (hs_cyc.size() == 2) check_eq("b2b_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);

      // add with carry and illegal function ids
      send(3'd2, 4'd3, 4'hF, 4'hF);
      send(3'd6, 4'd9, 4'h3, 4'h4);
      send(3'd2, 4'd4, 4'h7, 4'h2);
      send(3'd7, 4'd6, 4'hF, 4'hF);
      send(3'd0, 4'd7, 4'h0, 4'h0);
      send(3'd1, 4'd8, 4'h7, 4'h0);
      drain(40);

      // context task latency
      rsp_ready = 1'b0;
      send(3'd3, 4'hA, 4'h5, 4'h5);
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      check_eq("ctx_lat", 32'(n), 32'(1 + CTX));
      rsp_ready = 1'b1;
      drain(10);

      // fill the FIFO with the response held back
      rsp_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) send(3'(i % 3), 4'(8 + i), 4'(i), 4'(i + 1));
      check_eq("full_ready", 32'(req_ready), 32'd0);
      check_eq("full_out", 32'(outstanding), 32'(DEPTH + 1));
      req_func = 3'd2; req_tag = 4'hD; req_a = 4'h9; req_b = 4'h8; req_valid = 1'b1;
      tick(); tick();
      check_eq("full_hold_ready", 32'(req_ready), 32'd0);
      check_eq("full_no_accept", 32'(sb.size()), 32'(DEPTH + 1));
      rsp_ready = 1'b1;
      send(3'd2, 4'hD, 4'h9, 4'h8);
      drain(40);

      // reset while the context task is waiting with two calls queued
      rsp_ready = 1'b0;
      send(3'd3, 4'h1, 4'h0, 4'h0);
      send(3'd0, 4'h2, 4'h1, 4'h0);
      send(3'd1, 4'h3, 4'hF, 4'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check_eq("mid_rst_out",   32'(outstanding), 32'd0);
      check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check_eq("mid_rst_stale", 32'(rsp_valid), 32'd0);

      // post-reset traffic still works
      send(3'd2, 4'hE, 4'h8, 4'h8);
      drain(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
